// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } rx_state_e;

    // Last sample count of an 11-bit x 16-sample frame; the counter wraps after it.
    localparam logic [7:0] FRAME_LAST_COUNT = 8'd175;

    // Bit index = counter[7:4]
    localparam logic [3:0] BIT_START  = 4'd0;
    localparam logic [3:0] BIT_PARITY = 4'd9;
    localparam logic [3:0] BIT_STOP   = 4'd10;

    // Sample positions (counter[3:0]) that take part in the mid-bit vote.
    localparam logic [3:0] VOTE_POS_LO = 4'd7;
    localparam logic [3:0] VOTE_POS_HI = 4'd9;

    // Resolve a bit from the ones seen so far plus the final vote sample.
    function automatic logic vote_majority(input logic [1:0] ones_so_far, input logic last_sample);
        logic [2:0] total;
        total = {1'b0, ones_so_far} + {2'b00, last_sample};
        return (total >= 3'd2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RxD synchroniser: a chain of SYNC_STAGES flops, preset to the idle-high line level.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic rxs
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw line into the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    end

    // Chain registers; reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive control/data stage driven by an external 16x sample counter.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | counter held at 0, waiting for a low line on a sample tick
// ST_RECEIVE | counter advancing; voting, shifting, checking until wrap
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic        PARITY_ODD  = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    input  logic       Rx_sample_ENABLE,
    input  logic [7:0] counter,
    output logic       read_enable,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR
);

    logic       rxs;
    logic [3:0] bit_idx;
    logic [3:0] samp_pos;
    logic       in_vote_window;
    logic       resolved;
    logic       frame_end;

    rx_state_e  state_q, state_d;
    logic       read_enable_q, read_enable_d;
    logic [1:0] vote_q, vote_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       start_err_q, start_err_d;
    logic       stop_err_q, stop_err_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       perr_q, perr_d;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .rxd  (RxD),
        .rxs  (rxs)
    );

    assign bit_idx        = counter[7:4];
    assign samp_pos       = counter[3:0];
    assign in_vote_window = (samp_pos >= VOTE_POS_LO) && (samp_pos <= VOTE_POS_HI);
    assign resolved       = vote_majority(vote_q, rxs);
    assign frame_end      = (counter == FRAME_LAST_COUNT);

    // Next-state: start detection, mid-bit voting, bit placement and frame verdict.
    always_comb begin
        state_d       = state_q;
        read_enable_d = read_enable_q;
        vote_d        = vote_q;
        shift_d       = shift_q;
        par_d         = par_q;
        start_err_d   = start_err_q;
        stop_err_d    = stop_err_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        ferr_d        = ferr_q;
        perr_d        = perr_q;

        case (state_q)
            ST_IDLE: begin
                read_enable_d = 1'b1;
                if (Rx_sample_ENABLE && Rx_EN && !rxs) begin
                    state_d       = ST_RECEIVE;
                    read_enable_d = 1'b0;
                    vote_d        = 2'd0;
                    shift_d       = 8'h00;
                    par_d         = 1'b0;
                    start_err_d   = 1'b0;
                    stop_err_d    = 1'b0;
                    ferr_d        = 1'b0;
                    perr_d        = 1'b0;
                end
            end
            ST_RECEIVE: begin
                read_enable_d = 1'b0;
                if (Rx_sample_ENABLE) begin
                    if (in_vote_window) begin
                        if (samp_pos == VOTE_POS_HI) begin
                            vote_d = 2'd0;
                            if (bit_idx == BIT_START) begin
                                start_err_d = resolved;
                            end else if (bit_idx < BIT_PARITY) begin
                                shift_d = {resolved, shift_q[7:1]};
                            end else if (bit_idx == BIT_PARITY) begin
                                par_d = resolved;
                            end else if (bit_idx == BIT_STOP) begin
                                stop_err_d = !resolved;
                            end
                        end else begin
                            vote_d = vote_q + {1'b0, rxs};
                        end
                    end
                    // The counter wraps on this same edge, so the frame is closed here.
                    if (frame_end) begin
                        state_d       = ST_IDLE;
                        read_enable_d = 1'b1;
                        ferr_d        = start_err_q | stop_err_q;
                        perr_d        = ((^shift_q) ^ par_q) != PARITY_ODD;
                        if (!(ferr_d || perr_d)) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                read_enable_d = 1'b1;
            end
        endcase
    end

    // All controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            read_enable_q <= 1'b1;
            vote_q        <= 2'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            start_err_q   <= 1'b0;
            stop_err_q    <= 1'b0;
            data_q        <= 8'h00;
            valid_q       <= 1'b0;
            ferr_q        <= 1'b0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_enable_q <= read_enable_d;
            vote_q        <= vote_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            start_err_q   <= start_err_d;
            stop_err_q    <= stop_err_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            ferr_q        <= ferr_d;
            perr_q        <= perr_d;
        end
    end

    assign read_enable = read_enable_q;
    assign Rx_DATA     = data_q;
    assign Rx_VALID    = valid_q;
    assign Rx_FERROR   = ferr_q;
    assign Rx_PERROR   = perr_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Receiver control and data stage of the UART receive path. Sits directly downstream of bigcounter and drives bigcounter's read_enable input.
- Uses bigcounter's 8-bit sample count (0..175 = 11 bits × 16 oversamples) and Rx_sample_ENABLE to do the following:
  - detect the start bit,
  - majority-vote each bit at mid-bit,
  - shift in 8 data bits,
  - check parity and stop bit,
  - present the received byte with valid and error flags to the host side.

Parameters:
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected
- SYNC_STAGES, 2, number of flip-flops in the RxD synchroniser (≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; same reset net as bigcounter
- Rx_EN  in  1  receiver enable; gates start detection only
- RxD  in  1  asynchronous serial line, idle high
- Rx_sample_ENABLE  in  1  16× baud oversample tick, one clk wide
- counter  in  8  sample count from bigcounter
- read_enable  out  1  1 = idle/hold counter; 0 = frame in progress, counter advances
- Rx_DATA  out  8  last correctly received byte
- Rx_VALID  out  1  one-clk pulse when a frame completes with no errors
- Rx_FERROR  out  1  framing error (bad start or stop), held
- Rx_PERROR  out  1  parity error, held

Behaviour:
- Reset (synchronous, active-high), next edge:
  - state = IDLE, read_enable = 1
  - Rx_DATA = 0x00, Rx_VALID = 0, Rx_FERROR = 0, Rx_PERROR = 0
  - synchroniser flops = 1, shift register = 0
  - Reset mid-frame aborts the frame; bigcounter clears on the same reset.
- RxD passes through SYNC_STAGES flops; all logic uses the synchronised value rxs.
- The counter is decoded as: bit index = counter[7:4] (0 = start, 1..8 = D0..D7, 9 = parity, 10 = stop); sample position = counter[3:0].
- State IDLE:
  - read_enable = 1.
  - On a clk edge with Rx_sample_ENABLE = 1, Rx_EN = 1 and rxs = 0: go to RECEIVE, drive read_enable = 0, clear Rx_FERROR, Rx_PERROR and the vote/shift state.
  - The first following tick advances the counter to 1, so mid-bit is at position 8.
- State RECEIVE:
  - read_enable = 0.
  - On each Rx_SAMPLE tick at positions 7, 8 and 9 (value before increment), accumulate rxs into a 2-bit ones-count.
  - At the position-9 tick, resolve the bit: 1 if the count is ≥2, else 0. Then clear the accumulator.
  - Bit 0: resolved value 1 sets the internal start_err. There is no abort, because bigcounter can only return to 0 by wrapping at 175, so the frame runs to completion.
  - Bits 1..8: shift LSB-first into the data register.
  - Bit 9: store the parity bit.
  - Bit 10: stop value 0 sets stop_err.
- Frame end is the edge where counter = 175 and Rx_sample_ENABLE = 1; bigcounter wraps to 0 on the same edge. On that edge:
  - state returns to IDLE and read_enable = 1.
  - Rx_FERROR = start_err | stop_err.
  - Rx_PERROR = (XOR of data bits ^ parity bit) != PARITY_ODD.
  - If there are no errors: Rx_DATA = shift register and Rx_VALID = 1 for exactly the following clk cycle.
  - If there is any error: Rx_DATA is unchanged and Rx_VALID = 0.
- Error flags hold until the next start detection or reset.
- Rx_EN deasserted mid-frame: the frame completes normally; a new start is then blocked.
- Rx_sample_ENABLE low: state and accumulators hold.
- A start detected on the tick immediately after frame end is legal; back-to-back frames need no idle gap beyond one tick.
- Latency: Rx_VALID asserts 1 clk after the wrap edge.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE, RECEIVE),
  - constants FRAME_LAST_COUNT = 175, BIT_START = 0, BIT_PARITY = 9, BIT_STOP = 10,
  - VOTE_POS_LO = 7, VOTE_POS_HI = 9.
- One natural sub-module: uart_rx_sync, an RxD synchroniser parameterised by SYNC_STAGES.

Test Plan (bench instantiates bigcounter plus this block; Rx_sample_ENABLE every 4 clk; line driven 16 ticks per bit; PARITY_ODD = 0):
- Frame 0xA5, parity 0, stop 1 -> Rx_DATA = 0xA5, Rx_VALID high exactly 1 clk after counter wraps 175->0, both errors 0, read_enable back to 1.
- Frame 0x01 with parity bit 0 -> Rx_PERROR = 1, Rx_FERROR = 0, Rx_VALID never high, Rx_DATA stays 0xA5.
- Frame 0x3C with stop bit 0 -> Rx_FERROR = 1, Rx_VALID = 0; flag clears at the next start edge.
- RxD low for only sample ticks 0..2, then high -> start_err, frame runs 176 ticks, Rx_FERROR = 1, no Rx_VALID, read_enable = 1 afterwards.
- Frame 0x55 with a single inverted sample at position 8 of D3 -> majority vote recovers the bit: Rx_DATA = 0x55, Rx_VALID pulse, no errors.
- Reset asserted for 1 clk at counter = 90 -> next edge: read_enable = 1, all outputs 0, counter 0; the next frame 0x7E is received correctly with Rx_VALID.
